// File: rtl/tqvp_jnms_pdm_tx.sv
// TinyQV PCM-to-PDM transmitter: CPU-fed sample FIFO driving a first-order
// delta-sigma modulator that emits PDM clock and data on uo_out.
module tqvp_jnms_pdm_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FULL = FW'(FIFO_DEPTH);
  localparam logic [FW-1:0] HALF = FW'(FIFO_DEPTH / 2);

  logic              en_q, en_d, irq_en_q, irq_en_d;
  logic [7:0]        clkp_q, clkp_d, osr_q, osr_d;
  logic [7:0]        phase_q, phase_d, bitcnt_q, bitcnt_d;
  logic [15:0]       acc_q, acc_d, cur_q, cur_d;
  logic              pclk_q, pclk_d, pdat_q, pdat_d;
  logic              ovf_q, ovf_d, udf_q, udf_d, irq_q, irq_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [AW-1:0]     rptr_q, rptr_d, wptr_q, wptr_d;
  logic [FIFO_DEPTH-1:0][15:0] mem_q;

  logic        wr_en, ctrl_we, clkp_we, osr_we, push_req, rd_clr, flush, run;
  logic        step, pop_req, pop_ok, push_ok;
  logic [7:0]  per;
  logic [8:0]  osr_eff, bit_nxt;
  logic [15:0] sample, u;
  logic [16:0] s;

  assign wr_en    = (data_write_n != 2'b11);
  assign ctrl_we  = wr_en && (address == 6'h00);
  assign clkp_we  = wr_en && (address == 6'h04);
  assign push_req = wr_en && (address == 6'h08);
  assign osr_we   = wr_en && (address == 6'h0C);
  assign rd_clr   = (data_read_n == 2'b10) && (address == 6'h08);
  assign flush    = ctrl_we && data_in[3];
  // A write that clears enable stops the modulator in that same cycle.
  assign run      = en_q && !(ctrl_we && !data_in[0]);

  assign per     = (clkp_q < 8'd2) ? 8'd2 : clkp_q;
  assign osr_eff = (osr_q == 8'd0) ? 9'd256 : {1'b0, osr_q};
  assign bit_nxt = {1'b0, bitcnt_q} + 9'd1;
  assign step    = run && (phase_q == 8'd0);
  assign pop_req = step && (bitcnt_q == 8'd0);
  assign pop_ok  = pop_req && (fill_q != '0);
  // A pop in the same cycle frees a slot for a push into a full FIFO.
  assign push_ok = push_req && !flush && ((fill_q != FULL) || pop_ok);
  assign sample  = pop_ok ? mem_q[rptr_q] : cur_q;
  assign u       = sample ^ 16'h8000;
  assign s       = {1'b0, acc_q} + {1'b0, u};

  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    clkp_d   = clkp_q;
    osr_d    = osr_q;
    if (ctrl_we) begin
      en_d     = data_in[0];
      irq_en_d = data_in[1];
    end
    if (clkp_we) clkp_d = data_in[7:0];
    if (osr_we)  osr_d  = data_in[7:0];

    phase_d  = '0;
    bitcnt_d = '0;
    acc_d    = '0;
    pclk_d   = 1'b0;
    pdat_d   = 1'b0;
    cur_d    = cur_q;
    if (run) begin
      phase_d  = (phase_q == per - 8'd1) ? 8'd0 : phase_q + 8'd1;
      pclk_d   = (phase_q < (per >> 1));
      bitcnt_d = bitcnt_q;
      acc_d    = acc_q;
      pdat_d   = pdat_q;
      if (step) begin
        cur_d    = sample;
        bitcnt_d = (bit_nxt == osr_eff) ? 8'd0 : bit_nxt[7:0];
        acc_d    = s[15:0];
        pdat_d   = s[16];
      end
    end

    if (flush) begin
      fill_d = '0;
      rptr_d = '0;
      wptr_d = '0;
    end else begin
      fill_d = fill_q + FW'(push_ok) - FW'(pop_ok);
      rptr_d = rptr_q + AW'(pop_ok);
      wptr_d = wptr_q + AW'(push_ok);
    end

    // Sticky flags: a set in the clearing cycle still lands.
    ovf_d = (rd_clr ? 1'b0 : ovf_q) | (push_req && !push_ok && !flush);
    udf_d = (rd_clr ? 1'b0 : udf_q) | (pop_req && (fill_q == '0));
    irq_d = irq_en_q && (fill_q <= HALF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      clkp_q   <= '0;
      osr_q    <= '0;
      phase_q  <= '0;
      bitcnt_q <= '0;
      acc_q    <= '0;
      cur_q    <= '0;
      pclk_q   <= 1'b0;
      pdat_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      irq_q    <= 1'b0;
      fill_q   <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
    end else begin
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      clkp_q   <= clkp_d;
      osr_q    <= osr_d;
      phase_q  <= phase_d;
      bitcnt_q <= bitcnt_d;
      acc_q    <= acc_d;
      cur_q    <= cur_d;
      pclk_q   <= pclk_d;
      pdat_q   <= pdat_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      irq_q    <= irq_d;
      fill_q   <= fill_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= data_in[15:0];
  end

  always_comb begin
    data_out = '0;
    case (address)
      6'h00:   data_out = {30'b0, irq_en_q, en_q};
      6'h04:   data_out = {24'b0, clkp_q};
      6'h08:   data_out = {22'b0, 8'(fill_q), ovf_q, udf_q};
      6'h0C:   data_out = {24'b0, osr_q};
      default: data_out = '0;
    endcase
  end

  assign uo_out         = {5'b0, pdat_q, pclk_q, 1'b0};
  assign data_ready     = 1'b1;
  assign user_interrupt = irq_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in, data_in[31:16]};

endmodule

// File: tb/tb_tqvp_jnms_pdm_tx.sv
// Scoreboard bench for the PDM transmitter: stimulus queues expected PDM bits,
// a monitor pops and checks them on every rising pdm_clk.
module tb_tqvp_jnms_pdm_tx;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  tqvp_jnms_pdm_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          bits_seen = 0;
  logic [15:0] mfifo[$];
  bit          exp_q[$];
  logic        ovf_m = 1'b0, udf_m = 1'b0;
  logic [15:0] cur_m = 16'h0;
  logic        irq_b = 1'b0;
  logic        pclk_prev = 1'b0;
  bit          mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every pdm_clk rising edge presents one PDM bit.
  always @(negedge clk) begin
    if (rst_n && uo_out[1] && !pclk_prev) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pdm_bit: got unexpected bit %0b, expected none", uo_out[2]);
      end else begin
        mon_e = exp_q.pop_front();
        if (uo_out[2] !== mon_e) begin
          n_fail++;
          $display("FAIL pdm_bit #%0d: got %0b expected %0b", bits_seen, uo_out[2], mon_e);
        end
      end
      bits_seen++;
    end
    pclk_prev = uo_out[1];
  end

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
    address = a; data_in = d; data_write_n = w;
    @(posedge clk); #1;
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, input logic [1:0] w, output logic [31:0] d);
    address = a; data_read_n = w;
    #1 d = data_out;
    @(posedge clk); #1;
    data_read_n = 2'b11;
  endtask

  task automatic push(input logic [15:0] v);
    logic [1:0] w;
    w = 2'($urandom_range(0, 2));
    wr(6'h08, {16'($urandom), v}, w);
    if (mfifo.size() == DEPTH) ovf_m = 1'b1;
    else mfifo.push_back(v);
  endtask

  task automatic chk_status(input string nm, input logic [1:0] w);
    logic [31:0] d;
    rd(6'h08, w, d);
    chk(nm, d, {22'b0, 8'(mfifo.size()), ovf_m, udf_m});
    if (w == 2'b10) begin ovf_m = 1'b0; udf_m = 1'b0; end
  endtask

  // Enable, expect nbits PDM bits, then disable (optionally flushing).
  task automatic stream(input int clkp, input int osr, input int nbits,
                        input bit do_flush, input bit chk_clk);
    int oe, acc, p, target, cyc;
    logic [7:0] pat, pexp;
    wr(6'h04, 32'(clkp), 2'b10);
    wr(6'h0C, 32'(osr), 2'b00);
    oe = (osr == 0) ? 256 : osr;
    p = (clkp < 2) ? 2 : clkp;
    acc = 0;
    for (int b = 0; b < nbits; b++) begin
      if (b % oe == 0) begin
        if (mfifo.size() != 0) cur_m = mfifo.pop_front();
        else udf_m = 1'b1;
      end
      acc = acc + int'(cur_m ^ 16'h8000);
      exp_q.push_back(acc >= 65536);
      acc = acc % 65536;
    end
    target = bits_seen + nbits;
    wr(6'h00, {30'b0, irq_b, 1'b1}, 2'b00);
    if (chk_clk) begin
      pat = '0; pexp = '0;
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        pat[7-j] = uo_out[1];
        pexp[7-j] = (j >= 1) && (((j - 1) % p) < p / 2);
      end
      chk("pdm_clk_pattern", {24'b0, pat}, {24'b0, pexp});
    end
    cyc = 0;
    while (bits_seen < target && cyc < nbits * p + 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (bits_seen < target) begin
      n_tests++; n_fail++;
      $display("FAIL stream_timeout: got %0d bits expected %0d", bits_seen, target);
    end
    wr(6'h00, {28'b0, do_flush, 1'b0, irq_b, 1'b0}, 2'b00);
    if (do_flush) mfifo.delete();
    chk("pdm_off", {24'b0, uo_out}, 32'h0);
    chk("exp_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int n, ck, os, nb;
    ui_in = 8'($urandom);
    address = '0; data_in = '0; data_write_n = 2'b11; data_read_n = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_uo_out", {24'b0, uo_out}, 32'h0);
    chk("rst_irq", {31'b0, user_interrupt}, 32'h0);
    chk("data_ready", {31'b0, data_ready}, 32'h1);
    rd(6'h00, 2'b10, d); chk("rst_ctrl", d, 32'h0);
    rd(6'h04, 2'b10, d); chk("rst_clkp", d, 32'h0);
    rd(6'h08, 2'b10, d); chk("rst_status", d, 32'h0);
    rd(6'h0C, 2'b10, d); chk("rst_osr", d, 32'h0);
    wr(6'h04, 32'hA5, 2'b00);
    rd(6'h04, 2'b01, d); chk("clkp_rb", d, 32'hA5);
    rd(6'h10, 2'b10, d); chk("unmapped_rd", d, 32'h0);

    // Zero sample, CLKP=4 OSR=4, one underrun bit past the sample
    push(16'h0000);
    stream(4, 4, 5, 1'b0, 1'b1);
    chk_status("status_udf", 2'b10);
    chk_status("status_udf_clr", 2'b01);

    // Full-scale extremes
    push(16'h7FFF);
    stream(3, 0, 256, 1'b0, 1'b0);
    push(16'h8000);
    stream(2, 16, 16, 1'b0, 1'b1);
    chk_status("status_extremes", 2'b01);

    // Overflow: five pushes into a four-deep FIFO while disabled
    for (int i = 0; i < 5; i++) push(16'($urandom));
    chk_status("status_ovf", 2'b10);
    chk_status("status_ovf_clr", 2'b10);
    stream(5, 3, 12, 1'b0, 1'b0);
    chk_status("status_ovf_drain", 2'b01);

    // Interrupt level tracks fill with irq_en set, modulator idle
    irq_b = 1'b1;
    wr(6'h00, 32'hA, 2'b00);
    mfifo.delete();
    @(posedge clk); #1;
    chk("irq_fill0", {31'b0, user_interrupt}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      push(16'($urandom));
      @(posedge clk); #1;
      chk($sformatf("irq_fill%0d", mfifo.size()), {31'b0, user_interrupt},
          {31'b0, mfifo.size() <= DEPTH / 2});
    end
    stream(3, 2, 6, 1'b0, 1'b0);
    chk("irq_drained", {31'b0, user_interrupt}, 32'h1);
    irq_b = 1'b0;
    wr(6'h00, 32'h0, 2'b00);
    @(posedge clk); #1;
    chk("irq_masked", {31'b0, user_interrupt}, 32'h0);
    chk_status("status_irq", 2'b10);

    // Disable + flush mid-sample, then re-enable into an empty FIFO
    push(16'($urandom));
    push(16'($urandom));
    stream(3, 8, 3, 1'b1, 1'b0);
    chk_status("status_flush", 2'b01);
    stream(3, 8, 1, 1'b0, 1'b0);
    chk_status("status_reenable_udf", 2'b10);

    // Randomized streams, sometimes running past the queued samples
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) push(16'($urandom));
      ck = $urandom_range(0, 7);
      os = $urandom_range(1, 6);
      nb = n * os + $urandom_range(0, 2);
      stream(ck, os, nb, 1'b0, 1'b0);
      chk_status($sformatf("status_rand%0d", it), 2'b10);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
